// File: rtl/stack_arb_pkg.sv
// rtl/stack_arb_pkg.sv - shared state encoding and op constants for stack_arbiter
package stack_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arb_timer.sv
// rtl/stack_arb_timer.sv - busy-wait down-counter; done marks the final enabled cycle
module stack_arb_timer #(
    parameter int BUSY_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= 4'(BUSY_CYCLES);
        end else if (enable && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = enable && (count == 4'd1);

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester stack command arbiter; STACK_ARB_RR_EN selects round-robin
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int BUSY_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             op0,
    input  logic             op1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             err0,
    output logic             err1,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty
);

    state_t           state, next_state;
    logic             gnt_idx, gnt_op, gnt_err;
    logic [WIDTH-1:0] gnt_wdata, cap_data, pop_data;
    logic             any_req, win, win_op, reject, timer_done;
    logic [WIDTH-1:0] win_wdata;

    assign any_req = req0 | req1;

`ifdef STACK_ARB_RR_EN
    logic last_gnt;

    // Reset value 1 lets requester 0 win the first contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_gnt <= win;
        end
    end

    assign win = (req0 && req1) ? ~last_gnt : req1;
`else
    assign win = ~req0;
`endif

    assign win_op    = win ? op1 : op0;
    assign win_wdata = win ? wdata1 : wdata0;
    assign reject    = (win_op == OP_PUSH && stk_full) || (win_op == OP_POP && stk_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = reject ? DONE : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (timer_done) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_idx   <= 1'b0;
            gnt_op    <= OP_POP;
            gnt_err   <= 1'b0;
            gnt_wdata <= '0;
            cap_data  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt_idx   <= win;
                gnt_op    <= win_op;
                gnt_err   <= reject;
                gnt_wdata <= win_wdata;
            end
            if (state == WAIT && timer_done) begin
                cap_data <= stk_data_out;
            end
        end
    end

    stack_arb_timer #(
        .BUSY_CYCLES(BUSY_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (state == ISSUE),
        .enable(state == WAIT),
        .done  (timer_done)
    );

    assign pop_data = (gnt_op == OP_POP && !gnt_err) ? cap_data : '0;

    always_comb begin
        ack0        = 1'b0;
        ack1        = 1'b0;
        err0        = 1'b0;
        err1        = 1'b0;
        rdata0      = '0;
        rdata1      = '0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        case (state)
            ISSUE: begin
                stk_push    = (gnt_op == OP_PUSH);
                stk_pop     = (gnt_op == OP_POP);
                stk_data_in = gnt_wdata;
            end
            DONE: begin
                if (gnt_idx) begin
                    ack1   = 1'b1;
                    err1   = gnt_err;
                    rdata1 = pop_data;
                end else begin
                    ack0   = 1'b1;
                    err0   = gnt_err;
                    rdata0 = pop_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter against a queue-based stack model
module tb_stack_arbiter;
    import stack_arb_pkg::*;

    localparam int W     = 2;
    localparam int B     = 3;
    localparam int DEPTH = 4;

    logic         clk = 1'b0, rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [W-1:0] wdata0 = '0, wdata1 = '0;
    logic         ack0, ack1, err0, err1, stk_push, stk_pop;
    logic [W-1:0] rdata0, rdata1, stk_data_in;
    logic [W-1:0] stk_data_out = '0;
    logic         stk_full = 1'b0, stk_empty = 1'b1;

    stack_arbiter #(.WIDTH(W), .BUSY_CYCLES(B)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    typedef struct { logic op; logic [W-1:0] d; } cmd_t;
    typedef struct { int side; logic op; logic [W-1:0] wdata; logic err; logic [W-1:0] rdata; int rise; } exp_t;

    int           cyc = 0;
    int           n_cmp = 0, n_bad = 0;
    exp_t         sb[$];
    logic [W-1:0] ref_stk[$];
    logic [W-1:0] phys[$];
    int           rr_last = 1;
    cmd_t         cmds0[$], cmds1[$];
    int           gnt_log[$];
    int           last_ack = -100;
    int           cmd_cnt = 0, cmd_edge = 0;
    logic         cmd_op;
    logic [W-1:0] cmd_data;
    exp_t         mon_e;
    int           mon_s;
    int           exp_order[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // The stack device: commands take effect mid-cycle, data_out scrambled after each ack.
    always @(negedge clk) begin
        if (rst) begin
            phys.delete();
        end else begin
            if (stk_push) phys.push_back(stk_data_in);
            if (stk_pop) stk_data_out = (phys.size() > 0) ? phys.pop_back() : '0;
            if (ack0 || ack1) stk_data_out = W'($urandom);
        end
        stk_full  = (phys.size() >= DEPTH);
        stk_empty = (phys.size() == 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            cmd_cnt  = 0;
            last_ack = -100;
        end else begin
            if (stk_push || stk_pop) begin
                check("one_cmd", stk_push && stk_pop, 0);
                cmd_cnt++;
                cmd_op   = stk_push;
                cmd_data = stk_data_in;
                cmd_edge = cyc;
            end else begin
                check("data_in_idle", stk_data_in, 0);
            end
            if (ack0 || ack1) begin
                check("single_ack", ack0 && ack1, 0);
                gnt_log.push_back(int'(ack1));
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: ack0=%0d ack1=%0d expected none (cycle %0d)", ack0, ack1, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    mon_s = (mon_e.rise > last_ack + 2) ? mon_e.rise : last_ack + 2;
                    check("ack_side", ack1, mon_e.side);
                    check("err", mon_e.side != 0 ? err1 : err0, mon_e.err);
                    check("rdata", mon_e.side != 0 ? rdata1 : rdata0, mon_e.rdata);
                    check("latency", cyc - mon_s + 1, mon_e.err ? 1 : B + 2);
                    if (mon_e.err) begin
                        check("no_cmd_on_reject", cmd_cnt, 0);
                    end else begin
                        check("cmd_count", cmd_cnt, 1);
                        check("cmd_op", cmd_op, mon_e.op);
                        check("cmd_data", cmd_data, mon_e.wdata);
                        check("cmd_cycle", cmd_edge, mon_s);
                    end
                end
                last_ack = cyc;
                cmd_cnt  = 0;
            end
        end
    end

    function automatic exp_t ref_apply(input int side, input cmd_t c, input int rise);
        exp_t e;
        e.side = side; e.op = c.op; e.wdata = c.d; e.rise = rise; e.err = 1'b0; e.rdata = '0;
        if (c.op == OP_PUSH) begin
            if (ref_stk.size() == DEPTH) e.err = 1'b1;
            else ref_stk.push_back(c.d);
        end else begin
            if (ref_stk.size() == 0) e.err = 1'b1;
            else e.rdata = ref_stk.pop_back();
        end
        rr_last = side;
        return e;
    endfunction

    task automatic predict(input int rise);
        int i0 = 0, i1 = 0, w;
        while (i0 < cmds0.size() || i1 < cmds1.size()) begin
            if (i0 < cmds0.size() && i1 < cmds1.size()) begin
`ifdef STACK_ARB_RR_EN
                w = 1 - rr_last;
`else
                w = 0;
`endif
            end else begin
                w = (i0 < cmds0.size()) ? 0 : 1;
            end
            if (w == 0) begin sb.push_back(ref_apply(0, cmds0[i0], rise)); i0++; end
            else begin sb.push_back(ref_apply(1, cmds1[i1], rise)); i1++; end
        end
    endtask

    task automatic run_side(input int side);
        cmd_t c;
        int   budget;
        logic more;
        more = (side == 0) ? (cmds0.size() > 0) : (cmds1.size() > 0);
        while (more) begin
            if (side == 0) begin c = cmds0.pop_front(); op0 = c.op; wdata0 = c.d; req0 = 1'b1; end
            else begin c = cmds1.pop_front(); op1 = c.op; wdata1 = c.d; req1 = 1'b1; end
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!((side == 0) ? ack0 : ack1) && budget < 200);
            if (budget >= 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_timeout: side %0d got no ack within 200 cycles", side);
                more = 1'b0;
            end else begin
                more = (side == 0) ? (cmds0.size() > 0) : (cmds1.size() > 0);
            end
            if (!more) begin
                if (side == 0) req0 = 1'b0; else req1 = 1'b0;
            end
        end
    endtask

    task automatic run_batch();
        @(posedge clk); #1;
        predict(cyc + 1);
        fork
            run_side(0);
            run_side(1);
        join
        @(posedge clk); #1;
        check("sb_drained", sb.size(), 0);
        sb.delete();
        cmds0.delete();
        cmds1.delete();
    endtask

    function automatic cmd_t mk(input logic op, input logic [W-1:0] d);
        cmd_t c;
        c.op = op; c.d = d;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk(logic'($urandom_range(0, 1)), W'($urandom));
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_acks"}, {ack0, ack1, err0, err1}, 0);
        check({tag, "_rdata"}, {rdata0, rdata1}, 0);
        check({tag, "_stk_cmd"}, {stk_push, stk_pop}, 0);
        check({tag, "_stk_data_in"}, stk_data_in, 0);
    endtask

    task automatic reset_mid(input int phase);
        @(posedge clk); #1;
        op0    = (ref_stk.size() < DEPTH) ? OP_PUSH : OP_POP;
        wdata0 = 2'b11;
        req0   = 1'b1;
        repeat (phase + 1) @(posedge clk);
        #1;
        if (phase == 0) check("cmd_before_rst", stk_push | stk_pop, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        req0 = 1'b0;
        sb.delete();
        ref_stk.delete();
        rr_last = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #12;
        check_outputs_zero("reset_state");
        #1 rst = 1'b0;

        cmds0.push_back(mk(OP_POP, 2'b00));
        run_batch();
        cmds0.push_back(mk(OP_PUSH, 2'b10));
        run_batch();
        cmds1.push_back(mk(OP_PUSH, 2'b01));
        run_batch();
        cmds1.push_back(mk(OP_POP, 2'b00));
        run_batch();

`ifdef STACK_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            cmds0.push_back(mk(logic'(i < 2), W'(i)));
            cmds1.push_back(mk(logic'(i[0] == 1'b0), W'(i + 1)));
        end
        gnt_log.delete();
        run_batch();
        check("order_len", gnt_log.size(), 8);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) check("grant_order", gnt_log[i], exp_order[i]);

        reset_mid(2);
        cmds1.push_back(mk(OP_PUSH, 2'b10));
        run_batch();
        reset_mid(0);
        cmds0.push_back(mk(OP_PUSH, 2'b01));
        cmds1.push_back(mk(OP_PUSH, 2'b11));
        gnt_log.delete();
        run_batch();
        check("first_after_rst", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) cmds0.push_back(rnd_cmd());
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) cmds1.push_back(rnd_cmd());
            end else if ($urandom_range(0, 1) == 0) begin
                cmds0.push_back(rnd_cmd());
            end else begin
                cmds1.push_back(rnd_cmd());
            end
            run_batch();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
